// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: load-use stall, branch flush and memory-hold controller for the PC/step1/step2 pipeline registers
// Parameters:
//   STALL_CYCLES (1..15) - cycles a load-use stall lasts
//   CNT_W                - width of the saturating stall performance counter
// Ports:
//   clk, rst_n (async, active-low)
//   load_hazard_signal   - load-use hazard for the instruction in step1
//   branch_taken_step2   - branch in step2 resolved taken
//   hold_all             - memory wait, freeze everything
//   pc_we, step1_we      - PC / step1 register write enables
//   step1_flush          - load NOP into step1
//   step2_bubble         - load NOP into step2
//   pipe_we              - step2/3/4 register write enable
//   stall_active         - controller is in LOAD_STALL
//   stall_cnt            - saturating count of load-stall bubble cycles
module pipeline_stall_ctrl #(
  parameter int STALL_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_hazard_signal,
  input  logic             branch_taken_step2,
  input  logic             hold_all,
  output logic             pc_we,
  output logic             step1_we,
  output logic             step1_flush,
  output logic             step2_bubble,
  output logic             pipe_we,
  output logic             stall_active,
  output logic [CNT_W-1:0] stall_cnt
);
  typedef enum logic {RUN, LOAD_STALL} state_t;
  // The first stall cycle is spent in RUN, so LOAD_STALL covers the remaining STALL_CYCLES-1.
  localparam logic [3:0] REM_INIT = 4'(STALL_CYCLES - 2);
  state_t     state, state_nx;
  logic [3:0] rem, rem_nx;
  logic       br, stall, run;
  assign br    = !hold_all && branch_taken_step2;
  assign stall = !hold_all && !br && (state == LOAD_STALL || load_hazard_signal);
  assign run   = !hold_all && !br && !stall;
  // Outputs are forced low while reset is asserted, regardless of inputs.
  assign pc_we        = rst_n && (br || run);
  assign step1_we     = rst_n && (br || run);
  assign step1_flush  = rst_n && br;
  assign step2_bubble = rst_n && (br || stall);
  assign pipe_we      = rst_n && !hold_all;
  assign stall_active = rst_n && state == LOAD_STALL;
  always_comb begin
    state_nx = state;
    rem_nx   = rem;
    if (br) begin
      state_nx = RUN;
      rem_nx   = '0;
    end else if (stall) begin
      if (state == LOAD_STALL) begin
        state_nx = (rem == 4'd0) ? RUN : LOAD_STALL;
        rem_nx   = (rem == 4'd0) ? 4'd0 : rem - 4'd1;
      end else begin
        state_nx = (STALL_CYCLES == 1) ? RUN : LOAD_STALL;
        rem_nx   = (STALL_CYCLES == 1) ? 4'd0 : REM_INIT;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      rem       <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_nx;
      rem   <= rem_nx;
      if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

Pipeline freeze/bubble/flush controller that consumes `load_hazard_signal` from the decode-stage load-use hazard detector. It drives the write enables of the PC and the step1 (decode) pipeline register, inserts bubbles into step2 (execute), and flushes step1 on a taken branch resolved in step2. It also honours a global memory-wait hold and keeps a saturating count of load-stall cycles for performance measurement.

## Interface
- `STALL_CYCLES`, default 2: cycles a load-use stall lasts. Legal range 1..15. The default of 2 matches the load reaching step4 before the dependent instruction leaves step1.
- `CNT_W`, default 16: width of the stall performance counter.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `load_hazard_signal` input 1: load-use hazard detected for the instruction in step1 (combinational, same cycle).
- `branch_taken_step2` input 1: the BEQ/BNE in step2 resolved taken this cycle.
- `hold_all` input 1: memory wait; freeze the entire pipeline.
- `pc_we` output 1: PC write enable.
- `step1_we` output 1: step1 pipeline register write enable.
- `step1_flush` output 1: load a NOP into step1 at the next edge.
- `step2_bubble` output 1: load a NOP (opcode 0, t=0) into step2 at the next edge.
- `pipe_we` output 1: write enable for the step2/3/4 registers.
- `stall_active` output 1: the controller is in the LOAD_STALL state.
- `stall_cnt` output CNT_W: saturating count of load-stall bubble cycles.

## Operation
- States: RUN, LOAD_STALL. The 4-bit down-counter `rem` is valid only in LOAD_STALL.
- Outputs are Mealy: combinational from the state and the current inputs.
- Priority, highest first: reset, `hold_all`, `branch_taken_step2`, load stall.
- **While `rst_n` is low:**
  - state=RUN, rem=0, stall_cnt=0.
  - All outputs 0.
- **`hold_all`=1, any state:**
  - pc_we=step1_we=pipe_we=0; step1_flush=step2_bubble=0.
  - state, rem and stall_cnt are unchanged.
- **`branch_taken_step2`=1 (no hold):**
  - pc_we=1, step1_flush=1, step1_we=1 (flush is a write of NOP), pipe_we=1, step2_bubble=1.
  - Next state is RUN; an in-progress stall is cancelled.
  - `load_hazard_signal` is ignored this cycle.
- **RUN, `load_hazard_signal`=1:**
  - pc_we=0, step1_we=0, step2_bubble=1, pipe_we=1.
  - stall_cnt increments.
  - If STALL_CYCLES=1, stay in RUN. Otherwise go to LOAD_STALL with rem=STALL_CYCLES-2.
- **RUN, no hazard:** pc_we=step1_we=pipe_we=1; other outputs 0.
- **LOAD_STALL:**
  - Outputs are identical to the RUN-hazard case, and stall_cnt increments.
  - `load_hazard_signal` is ignored.
  - If rem==0, go to RUN; else rem decrements.
- **stall_cnt:**
  - Increments only on load-stall bubble cycles (not branch bubbles, not hold cycles).
  - Saturates at 2^CNT_W-1 with no wrap.
- `stall_active` = (state==LOAD_STALL).

## Timing
- Zero-cycle reaction: a hazard asserted in cycle c gives pc_we=0 in cycle c.
- A load-use stall occupies exactly STALL_CYCLES consecutive non-hold cycles (c .. c+STALL_CYCLES-1). The dependent instruction advances at the edge ending cycle c+STALL_CYCLES.
- `hold_all` cycles inside a stall extend it one-for-one and do not consume rem.
- Flush takes effect at the edge ending the cycle in which the branch is seen: 1 cycle, no state retained.
- Reset deasserted mid-stall: the controller is in RUN from the first clock edge after release, with no residual bubble.
- A hazard in the cycle immediately after a stall ends starts a new stall, with stall_cnt continuing.

## Test plan
- **Reset:** hold rst_n=0 for 3 cycles, release → during reset all outputs 0 and stall_cnt=0; first cycle after release pc_we=step1_we=pipe_we=1.
- **Single load stall, STALL_CYCLES=2:** pulse load_hazard_signal in cycle 5 → pc_we=0 and step2_bubble=1 in cycles 5–6, stall_active=1 in cycle 6, pc_we=1 in cycle 7, stall_cnt=2.
- **Hold inside stall:** hazard at cycle 5, hold_all=1 in cycle 6 → all enables 0 in cycle 6; bubble resumes cycle 7; RUN in cycle 8; stall_cnt=2.
- **Branch cancels stall:** hazard at cycle 5, branch_taken_step2=1 in cycle 6 → step1_flush=1 and pc_we=1 in cycle 6, RUN in cycle 7, stall_cnt=1.
- **Simultaneous hazard+branch in RUN** → flush only, stall_active stays 0, stall_cnt unchanged.
- **Saturation, CNT_W=3:** hold load_hazard_signal=1 continuously for 20 cycles → stall_cnt reaches 7 and stays 7.
